kpscan: RTL and testbench
=========================

// Module: kpscan
// PURPOSE
//  Autonomous 4x4 keypad scan controller. Sequences the keypad column drives,
//  samples the row returns, debounces them and queues key events in a 4-entry
//  FIFO. The CPU reads events over the Wishbone bus. It replaces software-timed
//  column writes; o_kp_int feeds the interrupt controller.
// PARAMETERS
//  CLKS_PER_COL  16'd1000  settle cycles per driven column before sampling rows (>=2)
//  DEBOUNCE_SCANS  3'd4  consecutive identical frames required to accept a change (1..7)
// PORTS
//  i_clk       in   1   system clock; sole clock
//  i_rst_n     in   1   synchronous reset, active low
//  i_wb_cyc    in   1   Wishbone cycle
//  i_wb_stb    in   1   Wishbone strobe
//  i_wb_we     in   1   Wishbone write enable
//  i_wb_addr   in   1   0 = control/status, 1 = event FIFO
//  i_wb_data   in   32  Wishbone write data
//  o_wb_ack    out  1   Wishbone acknowledge
//  o_wb_data   out  32  Wishbone read data
//  o_kp_col    out  4   column drives; a driven column is low
//  i_kp_row    in   4   row returns; pulled up, low = key closed on driven column
//  o_kp_int    out  1   high while FIFO non-empty
// BEHAVIOUR
//  - Reset values: o_kp_col=4'h0, o_wb_ack=0, o_wb_data=0, o_kp_int=0, FIFO empty,
//    overflow=0, enable=1, debounced state=16'h0, FSM=IDLE.
//  - i_kp_row passes through a 2-FF synchroniser. "rows" below means the synchronised value.
//  - Key index k = 4*col+row. Key code = {col[1:0],row[1:0]}.
//  - FSM IDLE: o_kp_col=4'h0. Stay while rows==4'hF and debounced state==0.
//    Otherwise go to SCAN with col=0.
//  - FSM SCAN: o_kp_col=~(4'b1<<col). Count CLKS_PER_COL cycles. On the last cycle,
//    latch ~rows into snap[4*col+:4] and increment col. After col 3, go to EVAL.
//  - FSM EVAL, 1 cycle:
//    - If snap==prev_snap, stable_cnt increments, saturating at 7. Else stable_cnt=1.
//      prev_snap<=snap.
//    - If stable_cnt (post-update) >= DEBOUNCE_SCANS and snap!=state, take the lowest k
//      with snap[k]!=state[k]. Toggle state[k] and emit an event for k.
//    - At most one event per frame. Remaining changes emit on later frames.
//    - Next state: IDLE if snap==0 and state (post-update)==0, else SCAN with col=0.
//  - Event push: entry {rel,code}, where rel=1 for a release. Full FIFO with no pop
//    in the same cycle: event dropped, overflow set (sticky), state still updated.
//    Push and pop in the same cycle both take effect.
//  - Wishbone: o_wb_ack=1 exactly one cycle after any cyc&&stb. o_wb_data is
//    registered in the same cycle as ack and holds its value otherwise.
//  - Read addr0: {overflow, count[2:0], enable, 11'h0, state[15:0]}.
//  - Write addr0: bit0 -> enable. bit31=1 clears overflow.
//  - Read addr1: FIFO non-empty returns {1'b1, 26'h0, rel, code[3:0]} and pops.
//    Empty returns 32'h0, no pop.
//  - Write addr1: acked, ignored.
//  - enable=0: FSM forced to IDLE next cycle (mid-scan aborted, col=0). state, snap,
//    prev_snap and stable_cnt cleared, no events generated. FIFO and overflow retained.
//  - o_kp_int registered: equals (count!=0) one cycle after count changes.
//  - Reset mid-scan returns everything to reset values on the next edge.
// CONFIGURATION
//  KPSCAN_RELEASE_EN defined: press and release transitions are both queued, rel
//    reflects the type.
//  KPSCAN_RELEASE_EN undefined: only presses are queued. Releases update state
//    silently. rel always reads 0.
// TESTING (CLKS_PER_COL=4, DEBOUNCE_SCANS=2, KPSCAN_RELEASE_EN defined)
//  - Reset, no keys -> o_kp_col stays 4'h0, addr0 reads 32'h0800_0000, o_kp_int=0.
//  - Hold key col1/row2 (row[2] low only while o_kp_col==4'hD) -> after 2 stable
//    frames o_kp_int=1. addr1 reads 32'h8000_0006, then 32'h0. addr0 state=16'h0040.
//  - Release that key -> event 32'h8000_0016. FSM returns to IDLE, o_kp_col=4'h0.
//  - Hold keys k=0 and k=5 together -> two events on consecutive frames:
//    32'h8000_0000, then 32'h8000_0005.
//  - Generate 5 events without reading -> count=4, overflow=1. Write addr0
//    32'h8000_0001 clears overflow, FIFO intact.
//  - Write enable=0 mid-scan -> next cycle o_kp_col=4'h0, state=0.
//    Re-enable -> scanning resumes from col 0.

Source files
------------

// File: rtl/kpscan.sv
// kpscan: autonomous 4x4 keypad scanner with debounce, 4-entry event FIFO and Wishbone access.
// Define KPSCAN_RELEASE_EN to queue release events as well as presses.
module kpscan #(
    parameter logic [15:0] CLKS_PER_COL   = 16'd1000,
    parameter logic [2:0]  DEBOUNCE_SCANS = 3'd4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_wb_cyc,
    input  logic        i_wb_stb,
    input  logic        i_wb_we,
    input  logic        i_wb_addr,
    input  logic [31:0] i_wb_data,
    output logic        o_wb_ack,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_kp_col,
    input  logic [3:0]  i_kp_row,
    output logic        o_kp_int
);
    typedef enum logic [1:0] {IDLE, SCAN, EVAL} fsm_t;
    fsm_t fsm;
    logic [3:0] row_m, rows;
    logic [1:0] col;
    logic [15:0] cnt, snap, prev_snap, keys, keys_nxt, diff;
    logic [2:0] stable, stable_nxt, count;
    logic [1:0] wr_ptr, rd_ptr;
    logic [4:0] fifo [4];
    logic [3:0] k;
    logic enable, overflow, run, req, wr0, rd1, pop, push, push_ok, take, rel;
    logic unused_wb_data;
    assign unused_wb_data = ^i_wb_data[30:1];
    assign req = i_wb_cyc && i_wb_stb;
    assign wr0 = req && i_wb_we && !i_wb_addr;
    assign rd1 = req && !i_wb_we && i_wb_addr;
    assign pop = rd1 && count != 3'd0;
    // A disable write takes effect on the same edge it is accepted
    assign run = wr0 ? i_wb_data[0] : enable;
    assign diff = snap ^ keys;
    assign stable_nxt = snap != prev_snap ? 3'd1 : stable == 3'd7 ? 3'd7 : stable + 3'd1;
    assign take = fsm == EVAL && run && stable_nxt >= DEBOUNCE_SCANS && diff != 16'h0;
    assign rel = keys[k];
    assign keys_nxt = take ? keys ^ (16'h1 << k) : keys;
`ifdef KPSCAN_RELEASE_EN
    assign push = take;
`else
    assign push = take && !rel;
`endif
    assign push_ok = push && (count != 3'd4 || pop);
    always_comb begin
        k = 4'd0;
        for (int i = 15; i >= 0; i--)
            if (diff[i]) k = 4'(i);
    end
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            row_m     <= 4'hF;
            rows      <= 4'hF;
            fsm       <= IDLE;
            col       <= 2'd0;
            cnt       <= 16'd0;
            snap      <= 16'h0;
            prev_snap <= 16'h0;
            stable    <= 3'd0;
            keys      <= 16'h0;
            o_kp_col  <= 4'h0;
        end else begin
            row_m <= i_kp_row;
            rows  <= row_m;
            if (!run) begin
                fsm       <= IDLE;
                col       <= 2'd0;
                cnt       <= 16'd0;
                snap      <= 16'h0;
                prev_snap <= 16'h0;
                stable    <= 3'd0;
                keys      <= 16'h0;
                o_kp_col  <= 4'h0;
            end else begin
                case (fsm)
                    IDLE: if (rows != 4'hF || keys != 16'h0) begin
                        fsm      <= SCAN;
                        col      <= 2'd0;
                        cnt      <= 16'd0;
                        o_kp_col <= 4'hE;
                    end
                    SCAN: if (cnt == CLKS_PER_COL - 16'd1) begin
                        snap[4*col +: 4] <= ~rows;
                        cnt              <= 16'd0;
                        col              <= col + 2'd1;
                        fsm              <= col == 2'd3 ? EVAL : SCAN;
                        o_kp_col         <= col == 2'd3 ? 4'h0 : ~(4'b1 << (col + 2'd1));
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                    EVAL: begin
                        stable    <= stable_nxt;
                        prev_snap <= snap;
                        keys      <= keys_nxt;
                        col       <= 2'd0;
                        cnt       <= 16'd0;
                        fsm       <= snap == 16'h0 && keys_nxt == 16'h0 ? IDLE : SCAN;
                        o_kp_col  <= snap == 16'h0 && keys_nxt == 16'h0 ? 4'h0 : 4'hE;
                    end
                    default: fsm <= IDLE;
                endcase
            end
        end
    end
    always_ff @(posedge i_clk)
        if (push_ok) fifo[wr_ptr] <= {rel, k};
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            wr_ptr    <= 2'd0;
            rd_ptr    <= 2'd0;
            count     <= 3'd0;
            overflow  <= 1'b0;
            enable    <= 1'b1;
            o_wb_ack  <= 1'b0;
            o_wb_data <= 32'h0;
            o_kp_int  <= 1'b0;
        end else begin
            o_wb_ack <= req;
            o_kp_int <= count != 3'd0;
            if (wr0) enable <= i_wb_data[0];
            // A drop in the same cycle as a clear still leaves overflow set
            if (wr0 && i_wb_data[31]) overflow <= 1'b0;
            if (push && !push_ok) overflow <= 1'b1;
            if (push_ok) wr_ptr <= wr_ptr + 2'd1;
            if (pop) rd_ptr <= rd_ptr + 2'd1;
            count <= count + {2'b0, push_ok} - {2'b0, pop};
            if (req && !i_wb_we)
                o_wb_data <= i_wb_addr ? (pop ? {1'b1, 26'h0, fifo[rd_ptr]} : 32'h0)
                                       : {overflow, count, enable, 11'h0, keys};
        end
    end
endmodule

// File: tb/tb_kpscan.sv
// tb_kpscan: table vectors, hand-written corner sequences and randomized key sets against a
// frame-level reference model of kpscan (CLKS_PER_COL=4, DEBOUNCE_SCANS=2).
module tb_kpscan;
`ifdef KPSCAN_RELEASE_EN
    localparam bit REL_EN = 1'b1;
`else
    localparam bit REL_EN = 1'b0;
`endif
    localparam int CPC = 4;
    localparam int FRAME = 4 * CPC + 1;
    // sync (2) + idle exit (1) + two full frames + interrupt register (1)
    localparam int IRQ_LAT = 2 + 1 + 2 * FRAME + 1;

    logic clk = 1'b0, rst_n = 1'b0, cyc = 1'b0, stb = 1'b0, we = 1'b0, adr = 1'b0;
    logic [31:0] wdat = 32'h0, rdat;
    logic ack, irq;
    logic [3:0] kp_col, kp_row;
    logic [15:0] keys = 16'h0;

    kpscan #(.CLKS_PER_COL(16'd4), .DEBOUNCE_SCANS(3'd2)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
        .i_wb_addr(adr), .i_wb_data(wdat), .o_wb_ack(ack), .o_wb_data(rdat),
        .o_kp_col(kp_col), .i_kp_row(kp_row), .o_kp_int(irq)
    );

    always #5 clk = ~clk;

    // Ideal keypad: a closed key pulls its row low while its column is driven low
    always_comb begin
        kp_row = 4'hF;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                if (keys[4*c+r] && kp_col[c] === 1'b0) kp_row[r] = 1'b0;
    end

    int n_cmp = 0, n_bad = 0;
    logic [15:0] m_state = 16'h0;
    logic m_ovf = 1'b0;
    logic [4:0] m_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic wb(input logic w, input logic a, input logic [31:0] d, output logic [31:0] r);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we = w; adr = a; wdat = d;
        @(negedge clk);
        cyc = 1'b0; stb = 1'b0; we = 1'b0; wdat = 32'h0;
        check("wb_ack", {31'h0, ack}, 32'h1);
        r = rdat;
    endtask

    task automatic set_keys(input logic [15:0] nk, input int frames);
        @(negedge clk);
        keys = nk;
        repeat (frames * FRAME) @(negedge clk);
    endtask

    // Model: once keys are held steady, every differing key is reported in ascending index order
    task automatic apply(input logic [15:0] nk);
        int n = 0;
        for (int i = 0; i < 16; i++)
            if (nk[i] != m_state[i]) begin
                n++;
                if (!m_state[i] || REL_EN) begin
                    if (m_q.size() == 4) m_ovf = 1'b1;
                    else m_q.push_back({m_state[i], 4'(i)});
                end
            end
        m_state = nk;
        set_keys(nk, n + 5);
    endtask

    task automatic expect_drain();
        logic [31:0] d;
        check("irq_level", {31'h0, irq}, {31'h0, m_q.size() != 0});
        wb(1'b0, 1'b0, 32'h0, d);
        check("status", d, {m_ovf, 3'(m_q.size()), 1'b1, 11'h0, m_state});
        while (m_q.size() > 0) begin
            wb(1'b0, 1'b1, 32'h0, d);
            check("event", d, {1'b1, 26'h0, m_q.pop_front()});
        end
        wb(1'b0, 1'b1, 32'h0, d);
        check("empty_read", d, 32'h0);
        check("irq_clear", {31'h0, irq}, 32'h0);
        wb(1'b1, 1'b0, 32'h8000_0001, d);
        m_ovf = 1'b0;
    endtask

    typedef struct {
        logic [15:0] keys;
        logic [15:0] st;
        int          n;
        logic [4:0]  e0;
        logic [4:0]  e1;
    } vec_t;

    initial begin
        vec_t tbl [6];
        logic [31:0] d;
        logic [4:0] exp_q [$];
        int n;
        tbl[0] = '{16'h0021, 16'h0021, 2, 5'h00, 5'h05};
        tbl[1] = '{16'h0000, 16'h0000, 2, 5'h10, 5'h15};
        tbl[2] = '{16'h8000, 16'h8000, 1, 5'h0F, 5'h00};
        tbl[3] = '{16'h8001, 16'h8001, 1, 5'h00, 5'h00};
        tbl[4] = '{16'h0001, 16'h0001, 1, 5'h1F, 5'h00};
        tbl[5] = '{16'h0000, 16'h0000, 1, 5'h10, 5'h00};

        repeat (3) @(negedge clk);
        check("rst_col", {28'h0, kp_col}, 32'h0);
        check("rst_ack", {31'h0, ack}, 32'h0);
        check("rst_data", rdat, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("idle_col", {28'h0, kp_col}, 32'h0);
        wb(1'b0, 1'b0, 32'h0, d);
        check("rst_status", d, 32'h0800_0000);

        @(negedge clk);
        keys = 16'h0040;
        n = 0;
        while (!irq && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("irq_latency", n, IRQ_LAT);
        wb(1'b0, 1'b1, 32'h0, d);
        check("press_evt", d, 32'h8000_0006);
        wb(1'b0, 1'b1, 32'h0, d);
        check("press_empty", d, 32'h0);
        check("press_irq_low", {31'h0, irq}, 32'h0);
        wb(1'b0, 1'b0, 32'h0, d);
        check("press_status", d, 32'h0800_0040);
        set_keys(16'h0000, 6);
        wb(1'b0, 1'b1, 32'h0, d);
        check("release_evt", d, REL_EN ? 32'h8000_0016 : 32'h0);
        check("release_idle", {28'h0, kp_col}, 32'h0);

        for (int i = 0; i < 6; i++) begin
            set_keys(tbl[i].keys, 8);
            exp_q.delete();
            for (int j = 0; j < tbl[i].n; j++)
                if (!(j == 0 ? tbl[i].e0[4] : tbl[i].e1[4]) || REL_EN)
                    exp_q.push_back(j == 0 ? tbl[i].e0 : tbl[i].e1);
            wb(1'b0, 1'b0, 32'h0, d);
            check("tbl_status", d, {1'b0, 3'(exp_q.size()), 1'b1, 11'h0, tbl[i].st});
            while (exp_q.size() > 0) begin
                wb(1'b0, 1'b1, 32'h0, d);
                check("tbl_event", d, {1'b1, 26'h0, exp_q.pop_front()});
            end
            wb(1'b0, 1'b1, 32'h0, d);
            check("tbl_empty", d, 32'h0);
            if (tbl[i].keys == 16'h0) check("tbl_idle_col", {28'h0, kp_col}, 32'h0);
        end

        set_keys(16'h001F, 10);
        check("ovf_irq", {31'h0, irq}, 32'h1);
        wb(1'b0, 1'b0, 32'h0, d);
        check("ovf_status", d, 32'hC800_001F);
        wb(1'b1, 1'b0, 32'h8000_0001, d);
        wb(1'b0, 1'b0, 32'h0, d);
        check("ovf_cleared", d, 32'h4800_001F);
        for (int i = 0; i < 4; i++) begin
            wb(1'b0, 1'b1, 32'h0, d);
            check("ovf_fifo", d, 32'h8000_0000 + i);
        end
        m_state = 16'h001F;
        apply(16'h0000);
        expect_drain();

        @(negedge clk);
        keys = 16'h0040;
        repeat (7) @(negedge clk);
        check("scan_col1", {28'h0, kp_col}, 32'h0000_000D);
        wb(1'b1, 1'b0, 32'h0, d);
        check("dis_col", {28'h0, kp_col}, 32'h0);
        repeat (40) @(negedge clk);
        check("dis_hold_col", {28'h0, kp_col}, 32'h0);
        wb(1'b0, 1'b0, 32'h0, d);
        check("dis_status", d, 32'h0);
        wb(1'b1, 1'b0, 32'h1, d);
        check("reen_col0", {28'h0, kp_col}, 32'h0000_000E);
        apply(16'h0040);
        expect_drain();
        apply(16'h0000);
        expect_drain();

        for (int i = 0; i < 20; i++) begin
            apply(16'($urandom) & 16'($urandom));
            if ($urandom_range(2, 0) != 0) expect_drain();
        end
        apply(16'h0000);
        expect_drain();

        set_keys(16'h0021, 6);
        @(negedge clk);
        rst_n = 1'b0;
        keys = 16'h0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid_rst_col", {28'h0, kp_col}, 32'h0);
        check("mid_rst_irq", {31'h0, irq}, 32'h0);
        check("mid_rst_data", rdat, 32'h0);
        repeat (5) @(negedge clk);
        wb(1'b0, 1'b0, 32'h0, d);
        check("mid_rst_status", d, 32'h0800_0000);
        wb(1'b0, 1'b1, 32'h0, d);
        check("mid_rst_fifo", d, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
